// File: rtl/if_stage.sv
// Instruction-fetch stage: program counter, IF/ID pipeline register, branch/jump
// redirect with a one-slot flush, and saturating stall/flush debug counters.
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter int          CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_PC,
  input  logic             en_IF,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  input  logic             jump,
  input  logic [31:0]      jump_target,
  input  logic [31:0]      instr_in,
  output logic [31:0]      imem_addr,
  output logic [31:0]      IF_ID_pc4,
  output logic [31:0]      IF_ID_instr,
  output logic             IF_ID_valid,
  output logic [4:0]       Rs_out_from_IF,
  output logic [4:0]       Rt_out_from_IF,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_ONE;
  endfunction

  logic [31:0]      pc_p0;
  logic [31:0]      pc4_p0;
  logic             redirect_p0;
  logic [31:0]      target_p0;

  logic [31:0]      pc4_p1;
  logic [31:0]      instr_p1;
  logic             vld_p1;

  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  // Stage 0: PC and next-PC selection. A stall masks any redirect request;
  // the stalled ID instruction presents it again once the stall releases.
  assign pc4_p0      = pc_p0 + 32'd4;
  assign redirect_p0 = en_PC & (branch_taken | jump);
  assign target_p0   = branch_taken ? branch_target : jump_target;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_p0 <= RESET_PC;
    end else if (en_PC) begin
      pc_p0 <= redirect_p0 ? target_p0 : pc4_p0;
    end
  end

  // Stage 1: IF/ID register; a redirect squashes the wrong-path fetch.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc4_p1   <= 32'h0000_0000;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
    end else if (en_IF) begin
      pc4_p1 <= pc4_p0;
      if (redirect_p0) begin
        instr_p1 <= NOP_INSTR;
        vld_p1   <= 1'b0;
      end else begin
        instr_p1 <= instr_in;
        vld_p1   <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if (!en_PC) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
      if (redirect_p0 && en_IF) begin
        flush_cnt_r <= sat_inc(flush_cnt_r);
      end
    end
  end

  assign imem_addr      = pc_p0;
  assign IF_ID_pc4      = pc4_p1;
  assign IF_ID_instr    = instr_p1;
  assign IF_ID_valid    = vld_p1;
  assign Rs_out_from_IF = instr_p1[25:21];
  assign Rt_out_from_IF = instr_p1[20:16];
  assign stall_cnt      = stall_cnt_r;
  assign flush_cnt      = flush_cnt_r;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: vector table plus scoreboard queue, with extra instances
// for counter saturation (CNT_W=4) and PC wrap (RESET_PC=0xFFFF_FFFC).
module tb_if_stage;

  logic        clk;
  logic        rst;
  logic        en_PC, en_IF, branch_taken, jump;
  logic [31:0] branch_target, jump_target;

  logic [31:0] addr_m, pc4_m, instr_m, imem_m;
  logic        vld_m;
  logic [4:0]  rs_m, rt_m;
  logic [15:0] stall_m, flush_m;

  logic [31:0] addr_s, pc4_s, instr_s, imem_s;
  logic        vld_s;
  logic [4:0]  rs_s, rt_s;
  logic [3:0]  stall_s, flush_s;

  logic [31:0] addr_w, pc4_w, instr_w, imem_w;
  logic        vld_w;
  logic [4:0]  rs_w, rt_w;
  logic [15:0] stall_w, flush_w;

  int checks = 0;
  int errors = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    if (a == 32'h0) return 32'h8C22_0004;
    return {6'h08, a[6:2], a[6:2] + 5'd3, a[15:0]};
  endfunction

  assign imem_m = mem(addr_m);
  assign imem_s = mem(addr_s);
  assign imem_w = mem(addr_w);

  if_stage dut (
    .clk(clk), .rst(rst), .en_PC(en_PC), .en_IF(en_IF),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instr_in(imem_m),
    .imem_addr(addr_m), .IF_ID_pc4(pc4_m), .IF_ID_instr(instr_m),
    .IF_ID_valid(vld_m), .Rs_out_from_IF(rs_m), .Rt_out_from_IF(rt_m),
    .stall_cnt(stall_m), .flush_cnt(flush_m)
  );

  if_stage #(.CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst), .en_PC(en_PC), .en_IF(en_IF),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instr_in(imem_s),
    .imem_addr(addr_s), .IF_ID_pc4(pc4_s), .IF_ID_instr(instr_s),
    .IF_ID_valid(vld_s), .Rs_out_from_IF(rs_s), .Rt_out_from_IF(rt_s),
    .stall_cnt(stall_s), .flush_cnt(flush_s)
  );

  if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst(rst), .en_PC(en_PC), .en_IF(en_IF),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_target(jump_target), .instr_in(imem_w),
    .imem_addr(addr_w), .IF_ID_pc4(pc4_w), .IF_ID_instr(instr_w),
    .IF_ID_valid(vld_w), .Rs_out_from_IF(rs_w), .Rt_out_from_IF(rt_w),
    .stall_cnt(stall_w), .flush_cnt(flush_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        en_pc, en_if, br, jmp;
    logic [31:0] btgt, jtgt;
    logic [31:0] e_addr, e_pc4;
    logic        e_vld, e_nop;
    int          e_stall, e_flush;
  } vec_t;

  typedef struct {
    logic [31:0] addr, pc4, instr;
    logic        vld;
    int          stall, flush;
  } exp_t;

  exp_t q[$];
  vec_t tbl[18];

  function automatic vec_t mk(input logic ep, ei, b, j, input logic [31:0] bt, jt,
                              input logic [31:0] ea, ep4, input logic ev, en,
                              input int es, ef);
    vec_t v;
    v.en_pc = ep; v.en_if = ei; v.br = b; v.jmp = j; v.btgt = bt; v.jtgt = jt;
    v.e_addr = ea; v.e_pc4 = ep4; v.e_vld = ev; v.e_nop = en;
    v.e_stall = es; v.e_flush = ef;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction

  // Drive one cycle (called at a falling edge), push expectation, compare after the edge.
  task automatic step(input vec_t v);
    exp_t e, g;
    en_PC = v.en_pc; en_IF = v.en_if; branch_taken = v.br; jump = v.jmp;
    branch_target = v.btgt; jump_target = v.jtgt;
    e.addr  = v.e_addr;
    e.pc4   = v.e_pc4;
    e.vld   = v.e_vld;
    e.instr = v.e_nop ? 32'h0 : mem(v.e_pc4 - 32'd4);
    e.stall = v.e_stall;
    e.flush = v.e_flush;
    q.push_back(e);
    @(posedge clk);
    #1;
    g = q.pop_front();
    chk("imem_addr", addr_m, g.addr);
    chk("IF_ID_pc4", pc4_m, g.pc4);
    chk("IF_ID_valid", {31'b0, vld_m}, {31'b0, g.vld});
    chk("IF_ID_instr", instr_m, g.instr);
    chk("Rs", {27'b0, rs_m}, {27'b0, g.instr[25:21]});
    chk("Rt", {27'b0, rt_m}, {27'b0, g.instr[20:16]});
    chk("stall_cnt", {16'b0, stall_m}, g.stall);
    chk("flush_cnt", {16'b0, flush_m}, g.flush);
    chk("stall_cnt_w4", {28'b0, stall_s}, sat15(g.stall));
    chk("flush_cnt_w4", {28'b0, flush_s}, sat15(g.flush));
    @(negedge clk);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"}, addr_m, 32'h0);
    chk({tag, "_valid"}, {31'b0, vld_m}, 32'h0);
    chk({tag, "_instr"}, instr_m, 32'h0);
    chk({tag, "_pc4"}, pc4_m, 32'h0);
    chk({tag, "_rs"}, {27'b0, rs_m}, 32'h0);
    chk({tag, "_rt"}, {27'b0, rt_m}, 32'h0);
    chk({tag, "_stall"}, {16'b0, stall_m}, 32'h0);
    chk({tag, "_flush"}, {16'b0, flush_m}, 32'h0);
    chk({tag, "_stall_w4"}, {28'b0, stall_s}, 32'h0);
    chk({tag, "_wrap_addr"}, addr_w, 32'hFFFF_FFFC);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    //               ePC eIF br jmp btgt          jtgt          addr          pc4           vld nop stall flush
    tbl[0]  = mk(1, 1, 0, 0, 32'h0,       32'h0,       32'h4,       32'h4,       1, 0, 0, 0);
    tbl[1]  = mk(1, 1, 0, 0, 32'h0,       32'h0,       32'h8,       32'h8,       1, 0, 0, 0);
    tbl[2]  = mk(1, 1, 0, 0, 32'h0,       32'h0,       32'hC,       32'hC,       1, 0, 0, 0);
    tbl[3]  = mk(1, 1, 0, 0, 32'h0,       32'h0,       32'h10,      32'h10,      1, 0, 0, 0);
    tbl[4]  = mk(0, 0, 0, 0, 32'h0,       32'h0,       32'h10,      32'h10,      1, 0, 1, 0);
    tbl[5]  = mk(0, 0, 1, 0, 32'h80,      32'h0,       32'h10,      32'h10,      1, 0, 2, 0);
    tbl[6]  = mk(1, 1, 0, 0, 32'h0,       32'h0,       32'h14,      32'h14,      1, 0, 2, 0);
    tbl[7]  = mk(1, 1, 0, 0, 32'h0,       32'h0,       32'h18,      32'h18,      1, 0, 2, 0);
    tbl[8]  = mk(1, 1, 1, 0, 32'h40,      32'h0,       32'h40,      32'h1C,      0, 1, 2, 1);
    tbl[9]  = mk(1, 1, 0, 0, 32'h0,       32'h0,       32'h44,      32'h44,      1, 0, 2, 1);
    tbl[10] = mk(0, 0, 1, 0, 32'h60,      32'h0,       32'h44,      32'h44,      1, 0, 3, 1);
    tbl[11] = mk(1, 1, 1, 0, 32'h60,      32'h0,       32'h60,      32'h48,      0, 1, 3, 2);
    tbl[12] = mk(1, 1, 0, 1, 32'h0,       32'h100,     32'h100,     32'h64,      0, 1, 3, 3);
    tbl[13] = mk(1, 1, 1, 1, 32'h200,     32'h300,     32'h200,     32'h104,     0, 1, 3, 4);
    tbl[14] = mk(1, 0, 0, 0, 32'h0,       32'h0,       32'h204,     32'h104,     0, 1, 3, 4);
    tbl[15] = mk(0, 1, 0, 0, 32'h0,       32'h0,       32'h204,     32'h208,     1, 0, 4, 4);
    tbl[16] = mk(1, 0, 1, 0, 32'h300,     32'h0,       32'h300,     32'h208,     1, 0, 4, 4);
    tbl[17] = mk(1, 1, 0, 0, 32'h0,       32'h0,       32'h304,     32'h304,     1, 0, 4, 4);

    rst = 1'b0; en_PC = 1'b1; en_IF = 1'b1; branch_taken = 1'b0; jump = 1'b0;
    branch_target = 32'h0; jump_target = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    chk_reset("reset");

    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 18; i++) begin
      step(tbl[i]);
      if (i == 0) begin
        chk("wrap_addr", addr_w, 32'h0);
        chk("wrap_pc4", pc4_w, 32'h0);
        chk("wrap_valid", {31'b0, vld_w}, 32'h1);
      end
    end

    // Long stall: 16-bit counter keeps counting, 4-bit counter pins at 15.
    for (int i = 0; i < 20; i++) begin
      v = mk(0, 0, 0, 0, 32'h0, 32'h0, 32'h304, 32'h304, 1, 0, 5 + i, 4);
      step(v);
    end

    // Reset asserted mid-redirect, between clock edges, takes effect at once.
    en_PC = 1'b1; en_IF = 1'b1; branch_taken = 1'b1; branch_target = 32'h500;
    #2;
    rst = 1'b0;
    #1;
    chk_reset("async_reset");
    @(posedge clk);
    #1;
    chk("reset_held_addr", addr_m, 32'h0);
    @(negedge clk);
    rst = 1'b1;
    step(mk(1, 1, 0, 0, 32'h0, 32'h0, 32'h4, 32'h4, 1, 0, 0, 0));
    chk("scoreboard_drained", q.size(), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter and the IF/ID pipeline register. Sits directly upstream of the hazard detection unit. It consumes that unit's en_PC/en_IF stall enables and feeds it the Rs/Rt fields of the instruction held in IF/ID. Also applies branch/jump redirects from ID with a one-slot flush, and keeps saturating stall/flush event counters for debug.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded on reset
- NOP_INSTR, 32'h0000_0000, instruction word inserted on flush/reset (sll $0,$0,0)
- CNT_W, 16, width of stall_cnt and flush_cnt

- clk  in  1  pipeline clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset (rst=0 resets immediately, independent of clk)
- en_PC  in  1  PC update enable from hazard unit; 0 = hold PC
- en_IF  in  1  IF/ID register enable from hazard unit; 0 = hold IF/ID
- branch_taken  in  1  ID-stage branch resolved taken
- branch_target  in  32  branch destination address
- jump  in  1  ID-stage j/jal
- jump_target  in  32  jump destination address
- instr_in  in  32  instruction memory read data for imem_addr (combinational memory)
- imem_addr  out  32  current PC, drives instruction memory
- IF_ID_pc4  out  32  registered PC+4 of the instruction in IF/ID
- IF_ID_instr  out  32  registered instruction
- IF_ID_valid  out  1  1 = IF/ID holds a real instruction, 0 = bubble
- Rs_out_from_IF  out  5  IF_ID_instr[25:21], combinational from register
- Rt_out_from_IF  out  5  IF_ID_instr[20:16], combinational from register
- stall_cnt  out  CNT_W  cycles with en_PC=0, saturating
- flush_cnt  out  CNT_W  flushes performed, saturating

## Operation
- redirect = en_PC & (branch_taken | jump). branch_taken has priority over jump when both are 1 (target = branch_target).
- Stall beats redirect: while en_PC=0, branch_taken/jump are ignored. The stalled ID instruction re-presents them once the stall releases.
- PC update, only when en_PC=1:
  - redirect: PC <= selected target.
  - otherwise: PC <= PC+4, modulo 2^32 (0xFFFF_FFFC wraps to 0x0).
- IF/ID update, evaluated in order:
  - en_IF=0: hold all IF/ID fields.
  - redirect: IF_ID_instr <= NOP_INSTR, IF_ID_valid <= 0, IF_ID_pc4 <= PC+4. This is the flush; the wrong-path fetch is squashed.
  - otherwise: IF_ID_instr <= instr_in, IF_ID_pc4 <= PC+4, IF_ID_valid <= 1.
- en_PC and en_IF are honoured independently. A mismatched pair, such as en_PC=1 with en_IF=0, is legal: the PC advances while IF/ID holds.
- stall_cnt increments each cycle en_PC=0. flush_cnt increments each cycle redirect=1 and en_IF=1. Both saturate at 2^CNT_W-1, with no wrap.
- Reset (rst=0, async):
  - PC=RESET_PC, IF_ID_instr=NOP_INSTR, IF_ID_valid=0, IF_ID_pc4=0, stall_cnt=0, flush_cnt=0.
  - Rs_out_from_IF=Rt_out_from_IF=0 for the default NOP.
  - Reset asserted mid-stall or mid-redirect discards all in-flight state.
- After rst deasserts, the first rising edge fetches RESET_PC.

## Timing
- Fetch latency: the instruction at address A appears on IF_ID_instr 1 cycle after imem_addr=A, provided en_IF=1.
- Redirect penalty: 1 bubble. In the cycle after redirect, IF_ID_valid=0 and imem_addr=target. The cycle after that, IF/ID holds the target instruction.
- Stall: each cycle en_PC=en_IF=0 holds imem_addr and IF/ID exactly. Release resumes with no lost or duplicated instruction.
- Rs/Rt outputs change only on clock edges or reset; there is no path from any input to them within the same cycle.
- rst release is synchronous to clk in the system. The block has no internal synchroniser.

## Test plan
- Reset: hold rst=0, toggle clk. Required: imem_addr=0x0, IF_ID_valid=0, IF_ID_instr=0x0, counters 0. Release, memory returns instr=0x8C220004 at 0x0: after 1 edge, IF_ID_instr=0x8C220004, IF_ID_pc4=0x4, Rs=1, Rt=2, imem_addr=0x4.
- Sequential fetch: 5 edges with enables high. Required: imem_addr steps 0x4,0x8,0xC,0x10,0x14; IF_ID_valid=1 throughout.
- Load-use stall: en_PC=en_IF=0 for 2 cycles at imem_addr=0x10. Required: imem_addr stays 0x10 and IF/ID holds; stall_cnt=2. On release, next IF_ID_pc4=0x14.
- Branch flush: branch_taken=1, branch_target=0x40 at PC=0x8. Required: next cycle imem_addr=0x40, IF_ID_valid=0, IF_ID_instr=NOP, flush_cnt=1. Following cycle IF_ID_pc4=0x44, valid=1.
- Stall and branch together: en_PC=en_IF=0 with branch_taken=1. Required: no redirect, PC held, flush_cnt unchanged. Next cycle with en=1 and branch still 1: redirect taken.
- Saturation and wrap: CNT_W=4, hold stall 20 cycles. Required: stall_cnt=15. Separately, RESET_PC=0xFFFF_FFFC, one edge: imem_addr=0x0. Then assert rst mid-run: outputs return to reset values immediately, without waiting for a clk edge.
